// File: rtl/branch_resolver.sv
// branch_resolver: issues branch predictor requests, captures each prediction,
// and keeps the predictions in order until execute resolves them. Every outcome
// is reported back to the predictor. Mispredictions flush all wrong-path state.
// Branch and mispredict statistics are kept in saturating counters.
module branch_resolver #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   br_fetch,
   output logic                   fetch_ready,
   output logic                   pred_request,
   input  logic                   prediction,
   output logic                   pred_valid,
   output logic                   pred_taken,
   input  logic                   br_resolve,
   input  logic                   br_actual,
   output logic                   pred_result,
   output logic                   pred_taken_out,
   output logic                   mispredict,
   output logic                   underflow_err,
   output logic [$clog2(DEPTH):0] inflight,
   output logic [CNT_W-1:0]       branch_count,
   output logic [CNT_W-1:0]       mispredict_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0] pred_q,        pred_d;
   logic [PTR_W-1:0] head_q,        head_d;
   logic [PTR_W-1:0] tail_q,        tail_d;
   logic [OCC_W-1:0] count_q,       count_d;
   logic             pending_q,     pending_d;
   logic             mispredict_q,  mispredict_d;
   logic             underflow_q,   underflow_d;
   logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   logic not_empty_c;
   logic pop_c;
   logic flush_c;
   logic push_c;
   logic accept_c;

   // Resolve handshake and flush detection against the oldest queued prediction
   assign not_empty_c = (count_q != '0);
   assign pop_c       = br_resolve & not_empty_c;
   assign flush_c     = pop_c & (pred_q[head_q] != br_actual);

   // Pending slot counts toward occupancy so a capture always has room to land
   assign inflight     = count_q + OCC_W'(pending_q);
   assign fetch_ready  = (inflight < OCC_W'(DEPTH)) & ~flush_c;
   assign accept_c     = br_fetch & fetch_ready;
   assign pred_request = accept_c;
   assign push_c       = pending_q & ~flush_c;

   // Fetch-side view of the prediction arriving for the last accepted branch
   assign pred_valid = pending_q;
   assign pred_taken = prediction;

   // Predictor update path; taken is held low when no update is issued
   assign pred_result    = pop_c;
   assign pred_taken_out = pop_c & br_actual;

   assign mispredict       = mispredict_q;
   assign underflow_err    = underflow_q;
   assign branch_count     = branch_cnt_q;
   assign mispredict_count = mispred_cnt_q;

   // Next-state: queue push/pop, flush, pulses and saturating statistics
   always_comb begin
      pred_d        = pred_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      pending_d     = accept_c;
      mispredict_d  = flush_c;
      underflow_d   = br_resolve & ~not_empty_c;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;

      if (flush_c) begin
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
         pending_d = 1'b0;
      end else begin
         if (pop_c) begin
            head_d = head_q + PTR_W'(1);
         end
         if (push_c) begin
            pred_d[tail_q] = prediction;
            tail_d         = tail_q + PTR_W'(1);
         end
         count_d = count_q + OCC_W'(push_c) - OCC_W'(pop_c);
      end

      if (accept_c && (branch_cnt_q != '1)) begin
         branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if (flush_c && (mispred_cnt_q != '1)) begin
         mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      end
   end

   // State registers; reset drops every in-flight entry at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_q        <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         pending_q     <= 1'b0;
         mispredict_q  <= 1'b0;
         underflow_q   <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         pred_q        <= pred_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         pending_q     <= pending_d;
         mispredict_q  <= mispredict_d;
         underflow_q   <= underflow_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: a directed cycle table, an async reset check and
// a randomized run against a queue-based reference model.
module tb_branch_resolver;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned IW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             br_fetch, br_resolve, br_actual;
   logic             fetch_ready, pred_request, pred_valid, pred_taken;
   logic             pred_result, pred_taken_out, mispredict, underflow_err;
   logic             prediction;
   logic [IW-1:0]    inflight;
   logic [CNT_W-1:0] branch_count, mispredict_count;

   // Simple 2-bit predictor stand-in; random predictions in the random phase
   logic [1:0] ctr;
   bit         use_rand = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .br_fetch(br_fetch), .fetch_ready(fetch_ready),
      .pred_request(pred_request), .prediction(prediction), .pred_valid(pred_valid),
      .pred_taken(pred_taken), .br_resolve(br_resolve), .br_actual(br_actual),
      .pred_result(pred_result), .pred_taken_out(pred_taken_out),
      .mispredict(mispredict), .underflow_err(underflow_err), .inflight(inflight),
      .branch_count(branch_count), .mispredict_count(mispredict_count));

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr        <= 2'b11;
         prediction <= 1'b1;
      end else begin
         if (pred_result) begin
            if (pred_taken_out && ctr != 2'b11) ctr <= ctr + 2'd1;
            else if (!pred_taken_out && ctr != 2'b00) ctr <= ctr - 2'd1;
         end
         prediction <= use_rand ? 1'($urandom_range(0, 1)) : ctr[1];
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0] in;   // {br_fetch, br_resolve, br_actual}
      logic [6:0] out;  // {req, fetch_ready, pred_valid, pred_result, taken_out, mispredict, underflow}
      int         infl;
      int         bcnt;
      int         mcnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [2:0] in, input logic [6:0] out, input int infl, bcnt, mcnt);
      vec_t v;
      v.in = in; v.out = out; v.infl = infl; v.bcnt = bcnt; v.mcnt = mcnt;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      br_fetch = 1'b0; br_resolve = 1'b0; br_actual = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model state
   bit mq[$];
   bit m_pend, m_mis, m_unf;
   int m_b, m_m;
   localparam int SAT = (1 << CNT_W) - 1;

   initial begin
      // one branch, correct resolve, fill to DEPTH, mispredict flush, underflow
      add(3'b100, 7'b1100000, 0, 0, 0);
      add(3'b000, 7'b0110000, 1, 1, 0);
      add(3'b000, 7'b0100000, 1, 1, 0);
      add(3'b011, 7'b0101100, 1, 1, 0);
      add(3'b000, 7'b0100000, 0, 1, 0);
      add(3'b100, 7'b1100000, 0, 1, 0);
      add(3'b100, 7'b1110000, 1, 2, 0);
      add(3'b100, 7'b1110000, 2, 3, 0);
      add(3'b100, 7'b1110000, 3, 4, 0);
      add(3'b100, 7'b0010000, 4, 5, 0);
      add(3'b100, 7'b0000000, 4, 5, 0);
      add(3'b111, 7'b0001100, 4, 5, 0);
      add(3'b100, 7'b1100000, 3, 5, 0);
      add(3'b010, 7'b0011000, 4, 6, 0);
      add(3'b000, 7'b0100010, 0, 6, 1);
      add(3'b011, 7'b0100000, 0, 6, 1);
      add(3'b000, 7'b0100001, 0, 6, 1);
      add(3'b000, 7'b0100000, 0, 6, 1);

      do_reset();
      #1;
      chk("reset_inflight", int'(inflight), 0);
      chk("reset_fetch_ready", int'(fetch_ready), 1);
      chk("reset_pred_valid", int'(pred_valid), 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         {br_fetch, br_resolve, br_actual} = tbl[i].in;
         #1;
         chk($sformatf("t%0d_req", i), int'(pred_request), int'(tbl[i].out[6]));
         chk($sformatf("t%0d_fetch_ready", i), int'(fetch_ready), int'(tbl[i].out[5]));
         chk($sformatf("t%0d_pred_valid", i), int'(pred_valid), int'(tbl[i].out[4]));
         chk($sformatf("t%0d_pred_result", i), int'(pred_result), int'(tbl[i].out[3]));
         chk($sformatf("t%0d_taken_out", i), int'(pred_taken_out), int'(tbl[i].out[2]));
         chk($sformatf("t%0d_mispredict", i), int'(mispredict), int'(tbl[i].out[1]));
         chk($sformatf("t%0d_underflow", i), int'(underflow_err), int'(tbl[i].out[0]));
         chk($sformatf("t%0d_inflight", i), int'(inflight), tbl[i].infl);
         chk($sformatf("t%0d_branch_count", i), int'(branch_count), tbl[i].bcnt);
         chk($sformatf("t%0d_mispred_count", i), int'(mispredict_count), tbl[i].mcnt);
         if (tbl[i].out[4]) chk($sformatf("t%0d_pred_taken", i), int'(pred_taken), 1);
      end

      // Async reset with three branches in flight, between clock edges
      @(negedge clk);
      br_fetch = 1'b1; br_resolve = 1'b0;
      repeat (3) @(negedge clk);
      br_fetch = 1'b0;
      @(negedge clk);
      #1;
      chk("pre_reset_inflight", int'(inflight), 3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_inflight", int'(inflight), 0);
      chk("async_rst_branch_count", int'(branch_count), 0);
      chk("async_rst_mispred_count", int'(mispredict_count), 0);
      chk("async_rst_fetch_ready", int'(fetch_ready), 1);
      chk("async_rst_pred_valid", int'(pred_valid), 0);

      // Randomized run against the reference model
      use_rand = 1'b1;
      do_reset();
      mq.delete(); m_pend = 0; m_mis = 0; m_unf = 0; m_b = 0; m_m = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit flush, pop, fr, req;
         int infl;
         @(negedge clk);
         br_fetch   = ($urandom_range(0, 99) < 60);
         br_resolve = ($urandom_range(0, 99) < 40);
         br_actual  = 1'($urandom_range(0, 1));
         #1;
         infl  = mq.size() + int'(m_pend);
         pop   = br_resolve && mq.size() > 0;
         flush = pop && (mq[0] != br_actual);
         fr    = (infl < DEPTH) && !flush;
         req   = br_fetch && fr;
         chk("r_inflight", int'(inflight), infl);
         chk("r_fetch_ready", int'(fetch_ready), int'(fr));
         chk("r_req", int'(pred_request), int'(req));
         chk("r_pred_valid", int'(pred_valid), int'(m_pend));
         chk("r_pred_taken", int'(pred_taken), int'(prediction));
         chk("r_pred_result", int'(pred_result), int'(pop));
         if (pop) chk("r_taken_out", int'(pred_taken_out), int'(br_actual));
         chk("r_mispredict", int'(mispredict), int'(m_mis));
         chk("r_underflow", int'(underflow_err), int'(m_unf));
         chk("r_branch_count", int'(branch_count), m_b);
         chk("r_mispred_count", int'(mispredict_count), m_m);
         // advance model across the coming edge
         m_unf = br_resolve && mq.size() == 0;
         m_mis = flush;
         if (flush) begin
            mq.delete();
            m_pend = 0;
            if (m_m < SAT) m_m++;
         end else begin
            if (pop) void'(mq.pop_front());
            if (m_pend) mq.push_back(prediction);
            m_pend = req;
         end
         if (req && m_b < SAT) m_b++;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
